uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit stage directly downstream of the UART1 write-data PIO register; consumes its 8-bit output byte plus a one-cycle write strobe.
- Buffers bytes in a small FIFO and serializes each one onto the UART TXD pin: 8 data bits, optional parity, 1 stop bit.
- Exposes full, busy and overflow status for readback through a neighbouring status PIO.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- tx_data  in  8  byte from the write-data PIO out_port
- tx_wr  in  1  one-cycle write strobe; tx_data is sampled on this cycle
- ovf_clr  in  1  clears the sticky overflow flag
- txd  out  1  serial output; idle high
- tx_full  out  1  FIFO full
- tx_busy  out  1  FIFO not empty or frame in progress
- tx_ovf  out  1  sticky flag; set when a write is dropped
- tx_done  out  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset (async, active-high): txd=1, tx_full=0, tx_busy=0, tx_ovf=0, tx_done=0; FIFO pointers and count cleared; FSM to IDLE; baud counter 0.
- Reset mid-frame: txd goes high immediately, the partial frame is abandoned and queued bytes are discarded.

FIFO:
- Write when tx_wr=1 and count<FIFO_DEPTH. A write while full is dropped and sets tx_ovf.
- Pop only from IDLE, when count>0.
- Simultaneous write and pop while full: the write is accepted and count is unchanged; tx_ovf is not set.
- tx_full = (count==FIFO_DEPTH), registered.
- Pointers wrap modulo FIFO_DEPTH.

tx_ovf:
- ovf_clr has priority over a simultaneous set.

FSM states and transitions:
- IDLE: txd=1. If count>0, pop into an 8-bit shift register, compute parity, clear the baud counter and go to START.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: txd=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to PARITY if PARITY!=0, else STOP.
- PARITY: txd = odd ? ~^byte : ^byte, for one bit period.
- STOP: txd=1 for one bit period. On its last cycle, pulse tx_done for one cycle and return to IDLE.

Timing and arithmetic:
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1. The bit boundary occurs when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- Latency: the first tx_wr into an empty idle block puts txd=0 three cycles after the strobe edge (write at edge 1, pop at edge 2, START registered at edge 3).
- txd is a registered output with no glitches.
- Back-to-back: the next frame's start bit begins 1 cycle after the previous stop bit ends, i.e. 1 idle clock of txd=1 extends the stop bit.
- Frame length: (10 + (PARITY!=0))*CLKS_PER_BIT + 1 clocks per byte when streaming.
- tx_busy = (count!=0) || (state!=IDLE).

Test Plan:
- Single byte: reset, CLKS_PER_BIT=4, PARITY=0, write 0xA5. txd shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1. Each level lasts 4 clocks. tx_done pulses once; tx_busy falls the cycle after.
- Odd parity: PARITY=1, write 0x03 -> parity bit = 1. Even parity: PARITY=2, write 0x07 -> parity bit = 1; write 0x03 -> parity bit = 0.
- Overflow:
  - FIFO_DEPTH=4, write 0x11,0x22,0x33,0x44,0x55,0x66 on consecutive cycles.
  - The first byte pops, so 0x11..0x55 are accepted; tx_full asserts.
  - 0x66 is dropped and tx_ovf=1.
  - Output order is 0x11,0x22,0x33,0x44,0x55.
  - ovf_clr clears tx_ovf; ovf_clr asserted together with a dropped write leaves tx_ovf=0.
- Simultaneous write and pop at full: FIFO full, write 0x77 on the exact cycle IDLE pops -> accepted, tx_ovf stays 0, 0x77 is transmitted last.
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF with 2 bytes queued. txd=1 asynchronously, tx_busy=0. After release, no further frames appear until a new write.
- Streaming: 3 bytes queued with CLKS_PER_BIT=4, PARITY=0. Start bits arrive exactly 41 clocks apart, with 3 tx_done pulses.

Source files
------------

// File: rtl/uart_tx_serializer.sv
//------------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit stage for UART1. Bytes arrive from the write-data PIO register as an
// 8-bit value qualified by a one-cycle write strobe. They are queued in a small
// byte FIFO and sent on txd one frame at a time: a start bit, 8 data bits LSB
// first, an optional parity bit and one stop bit.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   tx_data  in   [7:0] byte from the write-data PIO out_port
//   tx_wr    in   one-cycle write strobe; tx_data is sampled on this cycle
//   ovf_clr  in   clears the sticky overflow flag (wins over a same-cycle set)
//   txd      out  serial line, idle high, registered
//   tx_full  out  FIFO holds FIFO_DEPTH bytes, registered
//   tx_busy  out  FIFO not empty or a frame is in flight, registered
//   tx_ovf   out  sticky flag, set when a write is dropped because the FIFO is full
//   tx_done  out  one-cycle pulse on the last cycle of each stop bit
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period, 2..65535
//   FIFO_DEPTH    FIFO entries, power of two, 2..16
//   PARITY        0 = none, 1 = odd, 2 = even
//------------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  input  logic       ovf_clr,
  output logic       txd,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_ovf,
  output logic       tx_done
);

  //----------------------------------------------------------------------------
  // Derived constants
  //----------------------------------------------------------------------------
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      BAUD_ZERO = 16'd0;
  localparam logic [15:0]      BAUD_ONE  = 16'd1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [2:0]       IDX_LAST  = 3'd7;

  localparam logic PARITY_EN  = (PARITY != 0);
  localparam logic PARITY_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  //----------------------------------------------------------------------------
  // Parity of one byte; odd parity makes the total count of ones odd.
  //----------------------------------------------------------------------------
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    logic even_p;
    even_p = ^data;
    return odd ? ~even_p : even_p;
  endfunction

  //----------------------------------------------------------------------------
  // State
  //----------------------------------------------------------------------------
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  state_t           state_r;
  logic [7:0]       shift_r;
  logic [2:0]       bit_idx_r;
  logic [15:0]      baud_r;
  logic             par_r;

  //----------------------------------------------------------------------------
  // Combinational decode
  //----------------------------------------------------------------------------
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [CNT_W-1:0] count_next_s;
  logic [7:0]       head_s;
  logic             baud_last_s;

  // FIFO handshake: pop from IDLE, push unless full without a same-cycle pop
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    count_next_s = count_r;
    head_s       = mem_r[rd_ptr_r];
    baud_last_s  = (baud_r == BAUD_LAST);

    if ((state_r == ST_IDLE) && (count_r != CNT_ZERO)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end

    // A pop on the same edge frees the slot, so a full FIFO still takes the byte.
    if (tx_wr) begin
      if ((count_r != DEPTH_C) || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  //----------------------------------------------------------------------------
  // FIFO storage; contents need no reset because the pointers define validity
  //----------------------------------------------------------------------------
  // Write port of the byte FIFO
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers, occupancy and the full/busy/overflow status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      tx_full  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      // Pointers are PTR_W wide, so the power-of-two depth wraps naturally.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      tx_full <= (count_next_s == DEPTH_C);
      tx_busy <= (count_r != CNT_ZERO) || (state_r != ST_IDLE);

      // Clear has priority so software never loses a clear to a racing drop.
      if (ovf_clr) begin
        tx_ovf <= 1'b0;
      end else if (drop_s) begin
        tx_ovf <= 1'b1;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Frame sequencer. txd is registered from the current state, so the line
  // lags the state by one clock: a pop at edge N shows the start bit at N+1.
  //----------------------------------------------------------------------------
  // Serializer FSM with baud counter, shift register and registered txd/tx_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      baud_r    <= BAUD_ZERO;
      par_r     <= 1'b0;
      txd       <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          txd <= 1'b1;
          if (pop_s) begin
            shift_r   <= head_s;
            par_r     <= parity_bit(head_s, PARITY_ODD);
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            state_r   <= ST_START;
          end
        end

        ST_START: begin
          txd <= 1'b0;
          if (baud_last_s) begin
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            state_r   <= ST_DATA;
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end

        ST_DATA: begin
          txd <= shift_r[0];
          if (baud_last_s) begin
            baud_r  <= BAUD_ZERO;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == IDX_LAST) begin
              bit_idx_r <= 3'd0;
              state_r   <= PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end

        ST_PARITY: begin
          txd <= par_r;
          if (baud_last_s) begin
            baud_r  <= BAUD_ZERO;
            state_r <= ST_STOP;
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end

        ST_STOP: begin
          txd <= 1'b1;
          if (baud_last_s) begin
            baud_r  <= BAUD_ZERO;
            tx_done <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end

        default: begin
          txd     <= 1'b1;
          baud_r  <= BAUD_ZERO;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
//------------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer. Three instances share clock, reset,
// data and ovf_clr: one without parity (main), one odd, one even. Frames are
// decoded from txd by sampling every clock of every bit slot on the falling
// edge and comparing against hand-computed frame images.
//------------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       ovf_clr;
  logic       wr_main, wr_odd, wr_even;
  logic       txd_main, full_main, busy_main, ovf_main, done_main;
  logic       txd_odd, full_odd, busy_odd, ovf_odd, done_odd;
  logic       txd_even, full_even, busy_even, ovf_even, done_even;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int cyc       = 0;
  int done_cnt  = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(0)) dut_main (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(wr_main), .ovf_clr(ovf_clr),
    .txd(txd_main), .tx_full(full_main), .tx_busy(busy_main), .tx_ovf(ovf_main),
    .tx_done(done_main)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(1)) dut_odd (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(wr_odd), .ovf_clr(ovf_clr),
    .txd(txd_odd), .tx_full(full_odd), .tx_busy(busy_odd), .tx_ovf(ovf_odd),
    .tx_done(done_odd)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(2)) dut_even (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(wr_even), .ovf_clr(ovf_clr),
    .txd(txd_even), .tx_full(full_even), .tx_busy(busy_even), .tx_ovf(ovf_even),
    .tx_done(done_even)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for latency and spacing measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Count tx_done pulses of the main instance
  always @(posedge clk) if (done_main === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic txd_of(input int sel);
    case (sel)
      0:       return txd_main;
      1:       return txd_odd;
      default: return txd_even;
    endcase
  endfunction

  // Wait for a start bit, then sample every clock of nslots bit slots.
  // Returns on the falling edge of the final stop-bit clock.
  task automatic rx_frame(input int sel, input int nslots, input string tag,
                          output logic [10:0] bits, output logic stable, output int t0);
    logic got;
    got    = 1'b0;
    stable = 1'b1;
    bits   = 11'h000;
    t0     = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (txd_of(sel) === 1'b0) got = 1'b1;
    end
    t0 = cyc;
    check_val({tag, "_start_seen"}, 32'(got), 32'd1);
    if (got) begin
      for (int s = 0; s < nslots; s++) begin
        for (int k = 0; k < CPB; k++) begin
          if (s != 0 || k != 0) @(negedge clk);
          if (k == 0) bits[s] = txd_of(sel);
          else if (txd_of(sel) !== bits[s]) stable = 1'b0;
        end
      end
    end
  endtask

  logic [10:0] bits_a, bits_b;
  logic        st_a, st_b;
  int          t_a, t_b, c0, d0, lows, got_done;
  int          starts [3];
  logic [7:0]  ovf_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  ovf_order [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
  logic [7:0]  str_bytes [3] = '{8'h01, 8'h80, 8'hC3};

  initial begin
    reset   = 1'b1;
    tx_data = 8'h00;
    ovf_clr = 1'b0;
    wr_main = 1'b0;
    wr_odd  = 1'b0;
    wr_even = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_txd",  32'(txd_main),  32'd1);
    check_val("rst_full", 32'(full_main), 32'd0);
    check_val("rst_busy", 32'(busy_main), 32'd0);
    check_val("rst_ovf",  32'(ovf_main),  32'd0);
    check_val("rst_done", 32'(done_main), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ---- single byte 0xA5, no parity ----
    tx_data = 8'hA5;
    wr_main = 1'b1;
    c0 = cyc;
    d0 = done_cnt;
    @(negedge clk);
    wr_main = 1'b0;
    rx_frame(0, 10, "a5", bits_a, st_a, t_a);
    check_val("a5_latency", t_a - c0, 32'd3);
    check_val("a5_frame", 32'(bits_a[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
    check_val("a5_bit_len", 32'(st_a), 32'd1);
    check_val("a5_done_hi", 32'(done_main), 32'd1);
    check_val("a5_busy_hi", 32'(busy_main), 32'd1);
    @(negedge clk);
    check_val("a5_done_lo", 32'(done_main), 32'd0);
    check_val("a5_busy_lo", 32'(busy_main), 32'd0);
    check_val("a5_idle_txd", 32'(txd_main), 32'd1);
    repeat (2) @(negedge clk);
    check_val("a5_done_cnt", done_cnt - d0, 32'd1);

    // ---- parity: 0x03 to odd and even, then 0x07 to even ----
    tx_data = 8'h03;
    wr_odd  = 1'b1;
    wr_even = 1'b1;
    @(negedge clk);
    wr_odd  = 1'b0;
    wr_even = 1'b0;
    fork
      rx_frame(1, 11, "odd03", bits_a, st_a, t_a);
      rx_frame(2, 11, "even03", bits_b, st_b, t_b);
    join
    check_val("odd03_frame",  32'(bits_a), 32'({1'b1, 1'b1, 8'h03, 1'b0}));
    check_val("odd03_len",    32'(st_a), 32'd1);
    check_val("even03_frame", 32'(bits_b), 32'({1'b1, 1'b0, 8'h03, 1'b0}));
    repeat (3) @(negedge clk);
    tx_data = 8'h07;
    wr_even = 1'b1;
    @(negedge clk);
    wr_even = 1'b0;
    rx_frame(2, 11, "even07", bits_b, st_b, t_b);
    check_val("even07_frame", 32'(bits_b), 32'({1'b1, 1'b1, 8'h07, 1'b0}));
    check_val("even07_len",   32'(st_b), 32'd1);
    repeat (3) @(negedge clk);

    // ---- overflow, ovf_clr priority, write+pop while full ----
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          tx_data = ovf_bytes[i];
          wr_main = 1'b1;
          @(negedge clk);
          if (i == 4) begin
            check_val("ovf_full_at_55", 32'(full_main), 32'd1);
            check_val("ovf_clear_at_55", 32'(ovf_main), 32'd0);
          end
          if (i == 5) check_val("ovf_set_by_66", 32'(ovf_main), 32'd1);
        end
        tx_data = 8'h99;
        ovf_clr = 1'b1;
        @(negedge clk);
        wr_main = 1'b0;
        ovf_clr = 1'b0;
        check_val("ovf_clr_priority", 32'(ovf_main), 32'd0);
        tx_data = 8'h88;
        wr_main = 1'b1;
        @(negedge clk);
        wr_main = 1'b0;
        check_val("ovf_set_88", 32'(ovf_main), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_val("ovf_clr_alone", 32'(ovf_main), 32'd0);
        check_val("ovf_still_full", 32'(full_main), 32'd1);
        got_done = 0;
        for (int i = 0; i < 200 && got_done == 0; i++) begin
          @(negedge clk);
          if (done_main === 1'b1) got_done = 1;
        end
        check_val("simul_done_seen", got_done, 32'd1);
        tx_data = 8'h77;
        wr_main = 1'b1;
        @(negedge clk);
        wr_main = 1'b0;
        check_val("simul_no_ovf", 32'(ovf_main), 32'd0);
        check_val("simul_full", 32'(full_main), 32'd1);
      end
      begin
        for (int f = 0; f < 6; f++) begin
          rx_frame(0, 10, "ovf_rx", bits_b, st_b, t_b);
          check_val($sformatf("ovf_frame%0d", f), 32'(bits_b[9:0]),
                    32'({1'b1, ovf_order[f], 1'b0}));
        end
      end
    join
    repeat (3) @(negedge clk);
    check_val("ovf_done_cnt", done_cnt - d0, 32'd6);
    check_val("ovf_busy_end", 32'(busy_main), 32'd0);

    // ---- streaming: three queued bytes, start bits 41 clocks apart ----
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          tx_data = str_bytes[i];
          wr_main = 1'b1;
          @(negedge clk);
        end
        wr_main = 1'b0;
      end
      begin
        for (int f = 0; f < 3; f++) begin
          rx_frame(0, 10, "str_rx", bits_b, st_b, starts[f]);
          check_val($sformatf("str_frame%0d", f), 32'(bits_b[9:0]),
                    32'({1'b1, str_bytes[f], 1'b0}));
        end
      end
    join
    check_val("str_gap01", starts[1] - starts[0], 32'd41);
    check_val("str_gap12", starts[2] - starts[1], 32'd41);
    repeat (3) @(negedge clk);
    check_val("str_done_cnt", done_cnt - d0, 32'd3);

    // ---- reset during data bit 3 of 0xFF with two bytes queued ----
    tx_data = 8'hFF;
    wr_main = 1'b1;
    @(negedge clk);
    tx_data = 8'h12;
    @(negedge clk);
    tx_data = 8'h34;
    @(negedge clk);
    wr_main = 1'b0;
    repeat (17) @(negedge clk);
    check_val("mid_busy_before", 32'(busy_main), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("mid_txd_async",  32'(txd_main),  32'd1);
    check_val("mid_busy_async", 32'(busy_main), 32'd0);
    check_val("mid_full_async", 32'(full_main), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (txd_main !== 1'b1) lows++;
    end
    check_val("mid_no_frames", lows, 32'd0);
    check_val("mid_no_done", done_cnt - d0, 32'd0);
    check_val("mid_busy_after", 32'(busy_main), 32'd0);

    // ---- recovery after reset ----
    tx_data = 8'h5A;
    wr_main = 1'b1;
    @(negedge clk);
    wr_main = 1'b0;
    rx_frame(0, 10, "rec", bits_a, st_a, t_a);
    check_val("rec_frame", 32'(bits_a[9:0]), 32'({1'b1, 8'h5A, 1'b0}));
    check_val("rec_len", 32'(st_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
